reg_file_wb: RTL

REG_FILE_WB -- requirements
Module: reg_file_wb

---
 rtl/reg_file_wb_pkg.sv | 30 +++
 rtl/reg_file_wb_rf_read_mux.sv | 36 +++
 rtl/reg_file_wb.sv | 84 ++++++++
 3 files changed

// File: rtl/reg_file_wb_pkg.sv
// Shared widths and ALU select encodings for the register file, ALU and CPU top.
package reg_file_wb_pkg;

    localparam int DATA_W  = 8;
    localparam int REG_CNT = 8;
    localparam int ADDR_W  = 3;

    typedef enum logic [2:0] {
        ALU_FWD = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_sel_e;

    // FWD passes operand 2 through, matching the datapath's immediate/move path.
    function automatic logic [DATA_W-1:0] alu_eval(input alu_sel_e sel,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] res;
        res = b;
        case (sel)
            ALU_ADD: res = a + b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            default: res = b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/reg_file_wb_rf_read_mux.sv
// Read-value selector for one read port: newest of incoming write, write-back stage, array.
module rf_read_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 3,
    parameter int BYPASS     = 1
) (
    input  logic [AW-1:0]         i_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_arr_data,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wb_valid,
    input  logic [AW-1:0]         i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    generate
        if (BYPASS != 0) begin : g_bypass
            // The incoming write is younger than the write-back entry, so it wins.
            always_comb begin
                o_rd_data = i_arr_data;
                if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
                    o_rd_data = i_wr_data;
                end else if (i_wb_valid && (i_wb_addr == i_rd_addr)) begin
                    o_rd_data = i_wb_data;
                end
            end
        end else begin : g_array_only
            logic w_unused;
            assign w_unused  = ^{i_wr_en, i_wr_addr, i_wr_data, i_wb_valid, i_wb_addr, i_wb_data};
            assign o_rd_data = i_arr_data;
        end
    endgenerate

endmodule

// File: rtl/reg_file_wb.sv
// Register file with a one-entry write-back stage and registered dual read ports.
module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int REG_COUNT  = REG_CNT,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [AW-1:0]         WRITEREG,
    input  logic                  WRITEENABLE,
    input  logic [AW-1:0]         OUT1ADDRESS,
    input  logic [AW-1:0]         OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] REGOUT1,
    output logic [DATA_WIDTH-1:0] REGOUT2,
    output logic                  WBPENDING
);

    logic [DATA_WIDTH-1:0] r_array [REG_COUNT];
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic [AW-1:0]         r_wb_addr;
    logic                  r_wb_valid;
    logic [DATA_WIDTH-1:0] r_out1;
    logic [DATA_WIDTH-1:0] r_out2;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    rf_read_mux #(.DATA_WIDTH(DATA_WIDTH), .AW(AW), .BYPASS(BYPASS)) u_rd_mux1 (
        .i_rd_addr  (OUT1ADDRESS),
        .i_arr_data (r_array[OUT1ADDRESS]),
        .i_wr_en    (WRITEENABLE),
        .i_wr_addr  (WRITEREG),
        .i_wr_data  (IN),
        .i_wb_valid (r_wb_valid),
        .i_wb_addr  (r_wb_addr),
        .i_wb_data  (r_wb_data),
        .o_rd_data  (w_rd1)
    );

    rf_read_mux #(.DATA_WIDTH(DATA_WIDTH), .AW(AW), .BYPASS(BYPASS)) u_rd_mux2 (
        .i_rd_addr  (OUT2ADDRESS),
        .i_arr_data (r_array[OUT2ADDRESS]),
        .i_wr_en    (WRITEENABLE),
        .i_wr_addr  (WRITEREG),
        .i_wr_data  (IN),
        .i_wb_valid (r_wb_valid),
        .i_wb_addr  (r_wb_addr),
        .i_wb_data  (r_wb_data),
        .o_rd_data  (w_rd2)
    );

    // Commit of the old entry and capture of a new one share an edge, so no write is lost.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_array[i] <= '0;
            end
            r_wb_data  <= '0;
            r_wb_addr  <= '0;
            r_wb_valid <= 1'b0;
            r_out1     <= '0;
            r_out2     <= '0;
        end else begin
            r_wb_valid <= WRITEENABLE;
            if (WRITEENABLE) begin
                r_wb_data <= IN;
                r_wb_addr <= WRITEREG;
            end
            if (r_wb_valid) begin
                r_array[r_wb_addr] <= r_wb_data;
            end
            r_out1 <= w_rd1;
            r_out2 <= w_rd2;
        end
    end

    assign REGOUT1   = r_out1;
    assign REGOUT2   = r_out2;
    assign WBPENDING = r_wb_valid;

endmodule
